// File: rtl/proc_pkg.sv
// Shared definitions for the operand-fetch slice.
//   - instruction field positions ([31:27] op, [26:23] rd, [22:19] rs1,
//     [18:15] rs2, [14:0] imm)
//   - IMM_FORM_BIT: opcode bit selecting the immediate form
//   - state_t: fetch sequencer states
//   - default data / address / immediate widths
package proc_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 4;
  localparam int unsigned IMMW_DEF = 15;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 27;
  localparam int unsigned RD_MSB  = 26;
  localparam int unsigned RD_LSB  = 23;
  localparam int unsigned RS1_MSB = 22;
  localparam int unsigned RS1_LSB = 19;
  localparam int unsigned RS2_MSB = 18;
  localparam int unsigned RS2_LSB = 15;
  localparam int unsigned IMM_MSB = 14;
  localparam int unsigned IMM_LSB = 0;

  // Bit of the 5-bit opcode that selects the immediate form.
  localparam int unsigned IMM_FORM_BIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/fwd_unit.sv
// Writeback forwarding for one source operand.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_capture     : window in which writebacks are observed (READ/CAPT)
//   i_clear       : drop any pending forward (stage returning to IDLE)
//   i_src         : source register address of the current instruction
//   i_wb_we_n     : writeback enable, active low
//   i_wb_dir      : writeback address
//   i_wb_data     : writeback data
//   i_rf_data     : register file read data for this port
//   o_data        : operand after forwarding
module fwd_unit
  import proc_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_capture,
  input  logic          i_clear,
  input  logic [AW-1:0] i_src,
  input  logic          i_wb_we_n,
  input  logic [AW-1:0] i_wb_dir,
  input  logic [DW-1:0] i_wb_data,
  input  logic [DW-1:0] i_rf_data,
  output logic [DW-1:0] o_data
);

  logic          w_hit;
  logic          r_flag;
  logic [DW-1:0] r_data;

  assign w_hit = i_capture && !i_wb_we_n && (i_wb_dir == i_src);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
      r_data <= '0;
    end else if (i_clear) begin
      r_flag <= 1'b0;
    end else if (w_hit) begin
      r_flag <= 1'b1;
      r_data <= i_wb_data;
    end
  end

  // A hit in the current cycle bypasses the held value so that a write in
  // the capture cycle still reaches the operand registered at that edge.
  always_comb begin
    o_data = i_rf_data;
    if (w_hit) begin
      o_data = i_wb_data;
    end else if (r_flag) begin
      o_data = r_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage between the instruction queue and the execute stage.
// Reads two registers from a registered-read register file, applies
// writeback forwarding and immediate substitution, and presents
// {op, rd, opA, opB} over a valid/ready handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : instruction handshake, instr fields
//                           [31:27] op, [26:23] rd, [22:19] rs1,
//                           [18:15] rs2, [14:0] imm; op[4]=1 immediate form
//   DirA/DirB, RE_A/RE_B  : register file read address / active-low enable
//   DataA/DataB           : register file read data (one cycle after address)
//   wb_we_n/wb_dir/wb_data: register file write port (observed for forwarding)
//   out_valid / out_ready : operand handshake
//   out_op/out_rd/out_a/out_b : presented instruction and operands
module operand_fetch
  import proc_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned IMMW = IMMW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  output logic [AW-1:0] DirA,
  output logic [AW-1:0] DirB,
  output logic          RE_A,
  output logic          RE_B,
  input  logic [DW-1:0] DataA,
  input  logic [DW-1:0] DataB,
  input  logic          wb_we_n,
  input  logic [AW-1:0] wb_dir,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_op,
  output logic [AW-1:0] out_rd,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b
);

  state_t r_state;
  state_t w_state_nxt;

  // Incoming instruction fields
  logic [4:0]      w_in_op;
  logic [AW-1:0]   w_in_rd;
  logic [AW-1:0]   w_in_rs1;
  logic [AW-1:0]   w_in_rs2;
  logic [IMMW-1:0] w_in_imm;

  // Latched instruction
  logic [4:0]      r_op;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_rs1;
  logic [IMMW-1:0] r_imm;

  // Registered outputs
  logic            r_in_ready;
  logic [AW-1:0]   r_dir_a;
  logic [AW-1:0]   r_dir_b;
  logic            r_re_a;
  logic            r_re_b;
  logic            r_out_valid;
  logic [4:0]      r_out_op;
  logic [AW-1:0]   r_out_rd;
  logic [DW-1:0]   r_out_a;
  logic [DW-1:0]   r_out_b;

  logic            w_capture;
  logic            w_fwd_clear;
  logic            w_imm_form;
  logic [DW-1:0]   w_imm_ext;
  logic [DW-1:0]   w_fwd_a;
  logic [DW-1:0]   w_fwd_b;

  assign w_in_op  = instr[OP_MSB:OP_LSB];
  assign w_in_rd  = AW'(instr[RD_MSB:RD_LSB]);
  assign w_in_rs1 = AW'(instr[RS1_MSB:RS1_LSB]);
  assign w_in_rs2 = AW'(instr[RS2_MSB:RS2_LSB]);
  assign w_in_imm = instr[IMM_LSB+IMMW-1:IMM_LSB];

  assign w_imm_form  = r_op[IMM_FORM_BIT];
  assign w_imm_ext   = {{(DW-IMMW){r_imm[IMMW-1]}}, r_imm};
  assign w_capture   = (r_state == READ) || (r_state == CAPT);
  assign w_fwd_clear = (r_state == OUT) && out_ready;

  fwd_unit #(.DW(DW), .AW(AW)) u_fwd_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_capture),
    .i_clear   (w_fwd_clear),
    .i_src     (r_rs1),
    .i_wb_we_n (wb_we_n),
    .i_wb_dir  (wb_dir),
    .i_wb_data (wb_data),
    .i_rf_data (DataA),
    .o_data    (w_fwd_a)
  );

  // Port B tracks the address actually driven on DirB.
  fwd_unit #(.DW(DW), .AW(AW)) u_fwd_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_capture),
    .i_clear   (w_fwd_clear),
    .i_src     (r_dir_b),
    .i_wb_we_n (wb_we_n),
    .i_wb_dir  (wb_dir),
    .i_wb_data (wb_data),
    .i_rf_data (DataB),
    .o_data    (w_fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_nxt = READ;
      READ:    w_state_nxt = CAPT;
      CAPT:    w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_op        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_imm       <= '0;
      r_dir_a     <= '0;
      r_dir_b     <= '0;
      r_re_a      <= 1'b1;
      r_re_b      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_rd    <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
    end else begin
      // in_ready is a register that mirrors the upcoming state.
      r_in_ready <= (w_state_nxt == IDLE);
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= w_in_op;
            r_rd    <= w_in_rd;
            r_rs1   <= w_in_rs1;
            r_imm   <= w_in_imm;
            r_dir_a <= w_in_rs1;
            r_dir_b <= w_in_rs2;
            r_re_a  <= 1'b0;
            r_re_b  <= w_in_op[IMM_FORM_BIT];
          end
        end
        CAPT: begin
          r_out_op    <= r_op;
          r_out_rd    <= r_rd;
          r_out_a     <= w_fwd_a;
          r_out_b     <= w_imm_form ? w_imm_ext : w_fwd_b;
          r_out_valid <= 1'b1;
          r_re_a      <= 1'b1;
          r_re_b      <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign DirA      = r_dir_a;
  assign DirB      = r_dir_b;
  assign RE_A      = r_re_a;
  assign RE_B      = r_re_b;
  assign out_valid = r_out_valid;
  assign out_op    = r_out_op;
  assign out_rd    = r_out_rd;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a registered-read register file model, a
// stimulus process that issues instructions and pushes the expected result
// (register contents as of the end of the capture cycle, or the
// sign-extended immediate) into a queue, and a monitor that compares every
// presented output against the queue head.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [3:0]  DirA, DirB;
  logic        RE_A, RE_B;
  logic [31:0] DataA = '0;
  logic [31:0] DataB = '0;
  logic        wb_we_n = 1'b1;
  logic [3:0]  wb_dir = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_op;
  logic [3:0]  out_rd;
  logic [31:0] out_a, out_b;

  operand_fetch #(.DW(32), .AW(4), .IMMW(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .DirA      (DirA),
    .DirB      (DirB),
    .RE_A      (RE_A),
    .RE_B      (RE_B),
    .DataA     (DataA),
    .DataB     (DataB),
    .wb_we_n   (wb_we_n),
    .wb_dir    (wb_dir),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_rd    (out_rd),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned acc;
  } exp_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  dir;
    logic [31:0] data;
  } wr_t;

  exp_t        q[$];
  logic [31:0] mem [16];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          hs_count = 0;
  bit          wb_rand = 1'b0;
  int          rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
  bit          started = 1'b0;

  // Register file: registered read, write on the edge (read sees old data).
  always @(posedge clk) begin
    if (!RE_A) DataA <= mem[DirA];
    if (!RE_B) DataB <= mem[DirB];
    if (!wb_we_n) mem[wb_dir] <= wb_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [14:0] v);
    return v[14] ? {17'h1FFFF, v} : {17'h00000, v};
  endfunction

  // Monitor: compare every presented cycle against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      started = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!started) begin
          check("latency", cyc, q[0].acc + 2);
          started = 1'b1;
        end
        check("out_op", 32'(out_op), 32'(q[0].op));
        check("out_rd", 32'(out_rd), 32'(q[0].rd));
        check("out_a", out_a, q[0].a);
        check("out_b", out_b, q[0].b);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(q.pop_front());
          started = 1'b0;
          hs_count++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_rand) begin
      wb_we_n = 1'($urandom_range(0, 1));
      wb_dir  = 4'($urandom_range(0, 3));
      wb_data = $urandom();
    end
  endtask

  task automatic write_reg(input logic [3:0] d, input logic [31:0] v);
    wb_we_n = 1'b0;
    wb_dir  = d;
    wb_data = v;
    tick();
    wb_we_n = 1'b1;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q.size() != 0 || out_valid) && g < 100) begin
      tick();
      g++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_instr(input logic [31:0] ins, input bit keep_valid, input bit abort,
                          input wr_t w_rd, input wr_t w_cp, input bit use_const,
                          input logic [31:0] ca, input logic [31:0] cb,
                          output int unsigned acc);
    int          guard;
    logic [4:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic [14:0] imm;
    exp_t        e;
    op  = ins[31:27];
    rd  = ins[26:23];
    rs1 = ins[22:19];
    rs2 = ins[18:15];
    imm = ins[14:0];
    acc = 0;
    guard = 0;
    instr = ins;
    in_valid = 1'b1;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();                                   // accept edge
    acc = cyc;
    if (!keep_valid) in_valid = 1'b0;
    if (!wb_rand) begin
      wb_we_n = !w_rd.en; wb_dir = w_rd.dir; wb_data = w_rd.data;
    end
    check("read_DirA", 32'(DirA), 32'(rs1));
    check("read_DirB", 32'(DirB), 32'(rs2));
    check("read_RE_A", 32'(RE_A), 32'd0);
    check("read_RE_B", 32'(RE_B), 32'(op[4]));
    check("read_in_ready", 32'(in_ready), 32'd0);
    tick();                                   // into capture cycle
    if (!wb_rand) begin
      wb_we_n = !w_cp.en; wb_dir = w_cp.dir; wb_data = w_cp.data;
    end
    check("capt_RE_A", 32'(RE_A), 32'd0);
    check("capt_RE_B", 32'(RE_B), 32'(op[4]));
    if (abort) begin
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_RE_A", 32'(RE_A), 32'd1);
      check("rst_RE_B", 32'(RE_B), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_a", out_a, 32'd0);
      if (!wb_rand) wb_we_n = 1'b1;
      return;
    end
    tick();                                   // operands registered
    if (!wb_rand) wb_we_n = 1'b1;
    e.op  = op;
    e.rd  = rd;
    e.a   = use_const ? ca : mem[rs1];
    e.b   = use_const ? cb : (op[4] ? sext(imm) : mem[rs2]);
    e.acc = acc;
    q.push_back(e);
    check("rel_RE_A", 32'(RE_A), 32'd1);
    check("rel_RE_B", 32'(RE_B), 32'd1);
  endtask

  initial begin
    wr_t         none;
    int unsigned a1, a2;
    int          h0;
    none = '0;

    // Preload the register file while the DUT is held in reset.
    for (int i = 0; i < 16; i++) begin
      write_reg(4'(i), (i == 1) ? 32'd1 : (i == 2) ? 32'd7 : $urandom());
    end
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_RE_A", 32'(RE_A), 32'd1);
    check("rst_RE_B", 32'(RE_B), 32'd1);
    check("rst_DirA", 32'(DirA), 32'd0);
    check("rst_DirB", 32'(DirB), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Register form
    do_instr({5'h01, 4'd3, 4'd1, 4'd2, 15'd0}, 0, 0, none, none, 1, 32'd1, 32'd7, a1);
    wait_drain();
    // Immediate form, negative immediate
    do_instr({5'h11, 4'd5, 4'd1, 4'd0, 15'h7FFF}, 0, 0, none, none, 1, 32'd1, 32'hFFFF_FFFF, a1);
    wait_drain();
    // Capture-cycle forward to A
    do_instr({5'h02, 4'd4, 4'd1, 4'd2, 15'd0}, 0, 0, none, {1'b1, 4'd1, 32'hA5A5_0000},
             1, 32'hA5A5_0000, 32'd7, a1);
    wait_drain();
    // Read- and capture-cycle writes to rs1: the later one wins
    do_instr({5'h03, 4'd6, 4'd1, 4'd2, 15'd0}, 0, 0, {1'b1, 4'd1, 32'h1111_1111},
             {1'b1, 4'd1, 32'h2222_2222}, 1, 32'h2222_2222, 32'd7, a1);
    wait_drain();
    // Read-cycle forward to B
    do_instr({5'h04, 4'd7, 4'd1, 4'd2, 15'd0}, 0, 0, {1'b1, 4'd2, 32'h0000_BEEF}, none,
             1, 32'h2222_2222, 32'h0000_BEEF, a1);
    wait_drain();
    // Immediate form ignores a write to rs2; positive immediate
    do_instr({5'h1F, 4'd8, 4'd1, 4'd3, 15'h0123}, 0, 0, none, {1'b1, 4'd3, 32'hDEAD_0000},
             1, 32'h2222_2222, 32'h0000_0123, a1);
    wait_drain();
    // Register 0 is an ordinary register
    write_reg(4'd0, 32'h0BAD_F00D);
    do_instr({5'h05, 4'd0, 4'd0, 4'd0, 15'd0}, 0, 0, none, none, 1, 32'h0BAD_F00D,
             32'h0BAD_F00D, a1);
    wait_drain();

    // Backpressure: held outputs, writes to rs1 during OUT ignored
    rdy_mode = 1;
    do_instr({5'h06, 4'd9, 4'd1, 4'd2, 15'd0}, 0, 0, none, none, 1, 32'h2222_2222,
             32'h0000_BEEF, a1);
    h0 = hs_count;
    for (int i = 0; i < 10; i++) begin
      wb_we_n = 1'b0;
      wb_dir  = 4'd1;
      wb_data = $urandom();
      tick();
    end
    wb_we_n = 1'b1;
    check("bp_no_handshake", 32'(hs_count - h0), 32'd0);
    rdy_mode = 2;
    wait_drain();
    repeat (3) tick();
    check("bp_one_handshake", 32'(hs_count - h0), 32'd1);

    // Reset in the capture cycle abandons the instruction
    do_instr({5'h07, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 1, none, none, 0, '0, '0, a1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    h0 = hs_count;
    repeat (8) tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_no_output", 32'(hs_count - h0), 32'd0);

    // Back-to-back with in_valid held high
    do_instr({5'h08, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 0, none, none, 0, '0, '0, a1);
    do_instr({5'h19, 4'd2, 4'd3, 4'd1, 15'h4000}, 0, 0, none, none, 0, '0, '0, a2);
    check("b2b_spacing", a2 - a1, 32'd4);
    wait_drain();

    // Randomized traffic with random writebacks and backpressure
    wb_rand  = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] r;
      r = $urandom();
      r[22:19] = 4'($urandom_range(0, 3));
      r[18:15] = 4'($urandom_range(0, 3));
      do_instr(r, (i != 59) && ($urandom_range(0, 1) == 1), 0, none, none, 0, '0, '0, a1);
    end
    wb_rand  = 1'b0;
    wb_we_n  = 1'b1;
    rdy_mode = 2;
    wait_drain();
    repeat (3) tick();
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
